// File: rtl/counter_timer_low_wb.sv
// Low-word 32-bit counter/timer with a Wishbone register port.
// Runs standalone, or as the low half of a 64-bit counter chained to the
// high-word block through strobe / is_offset / stop_out / stop_in / enable_in.
module counter_timer_low_wb #(
    parameter logic [31:0] BASE_ADR = 32'h2300_0000,
    parameter logic [7:0]  CONFIG   = 8'h00,
    parameter logic [7:0]  VALUE    = 8'h04,
    parameter logic [7:0]  DATA     = 8'h08
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic [31:0] wb_dat_o,
    input  logic        enable_in,
    input  logic        stop_in,
    output logic        strobe,
    output logic        is_offset,
    output logic        stop_out,
    output logic        enable_out,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cfg;
    logic [31:0] value_reg;
    logic [31:0] value_cur, cur_d;
    logic        stop_d, strobe_d;
    logic        stop_out_q;
    logic [31:0] data_merged;

    logic valid, sel_cfg, sel_val, sel_dat;
    logic cfg_wr, val_wr, dat_wr;
    logic ena, oneshot, updown, chain, irq_ena;
    logic loc_enable, at_match, terminal, wrap;

    assign ena     = cfg[0];
    assign oneshot = cfg[1];
    assign updown  = cfg[2];
    assign chain   = cfg[3];
    assign irq_ena = cfg[4];

    assign valid   = wb_stb_i & wb_cyc_i;
    assign sel_cfg = (wb_adr_i == (BASE_ADR | {24'h0, CONFIG}));
    assign sel_val = (wb_adr_i == (BASE_ADR | {24'h0, VALUE}));
    assign sel_dat = (wb_adr_i == (BASE_ADR | {24'h0, DATA}));

    assign wb_ack_o = valid & (sel_cfg | sel_val | sel_dat);
    assign cfg_wr   = valid & wb_we_i & sel_cfg;
    assign val_wr   = valid & wb_we_i & sel_val;
    assign dat_wr   = valid & wb_we_i & sel_dat;

    assign wb_dat_o = sel_cfg ? {27'h0, cfg} :
                      sel_val ? value_reg : value_cur;

    assign loc_enable = ena & (chain ? enable_in : 1'b1);
    assign enable_out = ena;

    // Up counts to VALUE, down counts to zero; in chained mode the high
    // word must also be at its terminal value.
    assign at_match  = updown ? (value_cur == value_reg) : (value_cur == '0);
    assign terminal  = at_match & (chain ? stop_in : 1'b1);
    assign wrap      = updown ? (value_cur == '1) : (value_cur == '0);
    assign is_offset = chain & updown & (value_cur == '1) & (state_q == RUN);

    // Byte-lane merge of a DATA write into the running count
    always_comb begin
        data_merged = value_cur;
        for (int unsigned b = 0; b < 4; b++) begin
            if (wb_sel_i[b]) data_merged[8*b +: 8] = wb_dat_i[8*b +: 8];
        end
    end

    // CONFIG (lane 0 only) and VALUE (per lane) register writes
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            cfg       <= '0;
            value_reg <= '0;
        end else begin
            if (cfg_wr && wb_sel_i[0]) cfg <= wb_dat_i[4:0];
            if (val_wr) begin
                for (int unsigned b = 0; b < 4; b++) begin
                    if (wb_sel_i[b]) value_reg[8*b +: 8] <= wb_dat_i[8*b +: 8];
                end
            end
        end
    end

    // Next-state, next-count and chain-output logic
    always_comb begin
        state_d  = state_q;
        cur_d    = value_cur;
        stop_d   = stop_out;
        strobe_d = 1'b0;
        if (!loc_enable) begin
            state_d = IDLE;
            stop_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = RUN;
                    cur_d   = updown ? '0 : value_reg;
                    stop_d  = 1'b0;
                end
                RUN: begin
                    if (terminal) begin
                        stop_d = 1'b1;
                        if (oneshot) state_d = DONE;
                        else         cur_d   = updown ? '0 : value_reg;
                    end else begin
                        cur_d    = updown ? value_cur + 32'd1 : value_cur - 32'd1;
                        stop_d   = 1'b0;
                        strobe_d = chain & wrap;
                    end
                end
                DONE: begin
                    stop_d = 1'b1;
                    if (cfg_wr && wb_sel_i[0] && wb_dat_i[0]) begin
                        state_d = IDLE;
                        stop_d  = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    stop_d  = 1'b0;
                end
            endcase
        end
        // A bus write to DATA wins over counting and freezes the FSM for the cycle
        if (dat_wr) begin
            state_d  = state_q;
            cur_d    = data_merged;
            stop_d   = stop_out;
            strobe_d = 1'b0;
        end
    end

    // FSM state and counter datapath registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            value_cur <= '0;
            stop_out  <= 1'b0;
            strobe    <= 1'b0;
        end else begin
            state_q   <= state_d;
            value_cur <= cur_d;
            stop_out  <= stop_d;
            strobe    <= strobe_d;
        end
    end

    // One-cycle interrupt on each rising edge of stop_out
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            stop_out_q <= 1'b0;
            irq        <= 1'b0;
        end else begin
            stop_out_q <= stop_out;
            irq        <= irq_ena & stop_out & ~stop_out_q;
        end
    end

endmodule

// File: tb/tb_counter_timer_low_wb.sv
// Self-checking bench for counter_timer_low_wb: a table of bus vectors plus
// hand-written counting sequences, all checked through an expectation queue.
module tb_counter_timer_low_wb;

    localparam logic [31:0] A_CFG = 32'h2300_0000;
    localparam logic [31:0] A_VAL = 32'h2300_0004;
    localparam logic [31:0] A_DAT = 32'h2300_0008;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] adr, dat_i, dat_o;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack;
    logic        enable_in, stop_in;
    logic        strobe, is_offset, stop_out, enable_out, irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic        exp_ack;
        logic        chk_dat;
        logic [31:0] exp_dat;
    } vec_t;
    vec_t vecs[13];

    counter_timer_low_wb #(
        .BASE_ADR(32'h2300_0000)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wb_adr_i  (adr),
        .wb_dat_i  (dat_i),
        .wb_sel_i  (sel),
        .wb_we_i   (we),
        .wb_cyc_i  (cyc),
        .wb_stb_i  (stb),
        .wb_ack_o  (ack),
        .wb_dat_o  (dat_o),
        .enable_in (enable_in),
        .stop_in   (stop_in),
        .strobe    (strobe),
        .is_offset (is_offset),
        .stop_out  (stop_out),
        .enable_out(enable_out),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input string n, input logic [31:0] e);
        exp_t x;
        x.name = n;
        x.exp  = e;
        sb.push_back(x);
    endtask

    task automatic check_pop(input logic [31:0] act);
        exp_t x;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual=%h required=<queued expectation>", act);
        end else begin
            x = sb.pop_front();
            if (act !== x.exp) begin
                errors++;
                $display("FAIL %s actual=%h required=%h", x.name, act, x.exp);
            end
        end
    endtask

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] e);
        push_exp(n, e);
        check_pop(act);
    endtask

    task automatic bus_idle();
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        adr = '0; dat_i = '0; sel = '0;
    endtask

    // Called at a negedge; the write commits on the following posedge.
    task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic exp_ack);
        adr = a; dat_i = d; sel = s; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        push_exp("wr_ack", {31'h0, exp_ack});
        #1 check_pop({31'h0, ack});
        @(negedge clk);
        bus_idle();
    endtask

    // Combinational read taken between edges; consumes no clock.
    task automatic wb_read(input string n, input logic [31:0] a, input logic exp_ack,
                           input logic chk_dat, input logic [31:0] exp_dat);
        adr = a; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        push_exp({n, "_ack"}, {31'h0, exp_ack});
        if (chk_dat) push_exp(n, exp_dat);
        #1;
        check_pop({31'h0, ack});
        if (chk_dat) check_pop(dat_o);
        bus_idle();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        enable_in = 1'b0;
        stop_in = 1'b0;
        bus_idle();

        vecs[0]  = '{A_VAL, 1'b1, 4'hF, 32'hA5A5_1234, 1'b1, 1'b0, 32'h0};
        vecs[1]  = '{A_VAL, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'hA5A5_1234};
        vecs[2]  = '{A_VAL, 1'b1, 4'h4, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0};
        vecs[3]  = '{A_VAL, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'hA5FF_1234};
        vecs[4]  = '{A_CFG, 1'b1, 4'hE, 32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0};
        vecs[5]  = '{A_CFG, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'h0};
        vecs[6]  = '{A_CFG, 1'b1, 4'h1, 32'hFFFF_FF1E, 1'b1, 1'b0, 32'h0};
        vecs[7]  = '{A_CFG, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'h0000_001E};
        vecs[8]  = '{A_DAT, 1'b1, 4'hF, 32'h1122_3344, 1'b1, 1'b0, 32'h0};
        vecs[9]  = '{A_DAT, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'h1122_3344};
        vecs[10] = '{32'h2300_000C, 1'b0, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0};
        vecs[11] = '{32'h2300_0010, 1'b1, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
        vecs[12] = '{A_DAT, 1'b0, 4'hF, 32'h0,         1'b1, 1'b1, 32'h1122_3344};

        // Reset state while reset is held
        #2;
        chk("rst_stop_out", {31'h0, stop_out}, 32'h0);
        chk("rst_strobe", {31'h0, strobe}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_ack_idle", {31'h0, ack}, 32'h0);
        wb_read("rst_cfg", A_CFG, 1'b1, 1'b1, 32'h0);
        wb_read("rst_val", A_VAL, 1'b1, 1'b1, 32'h0);
        wb_read("rst_dat", A_DAT, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Register access table (enable stays 0, nothing counts)
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (vecs[i].we)
                wb_write(vecs[i].adr, vecs[i].dat, vecs[i].sel, vecs[i].exp_ack);
            else
                wb_read("vec_rd", vecs[i].adr, vecs[i].exp_ack, vecs[i].chk_dat, vecs[i].exp_dat);
        end
        chk("vec_enable_out", {31'h0, enable_out}, 32'h0);

        // Standalone up oneshot, irq enabled
        apply_reset();
        wb_write(A_VAL, 32'd5, 4'hF, 1'b1);
        wb_write(A_CFG, 32'h17, 4'h1, 1'b1);
        chk("t1_enable_out", {31'h0, enable_out}, 32'h1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wb_read("t1_data", A_DAT, 1'b1, 1'b1, 32'(i));
            chk("t1_stop_low", {31'h0, stop_out}, 32'h0);
        end
        @(negedge clk);
        wb_read("t1_data_term", A_DAT, 1'b1, 1'b1, 32'd5);
        chk("t1_stop_rise", {31'h0, stop_out}, 32'h1);
        chk("t1_irq_not_yet", {31'h0, irq}, 32'h0);
        @(negedge clk);
        chk("t1_irq_pulse", {31'h0, irq}, 32'h1);
        chk("t1_stop_held", {31'h0, stop_out}, 32'h1);
        @(negedge clk);
        chk("t1_irq_end", {31'h0, irq}, 32'h0);
        chk("t1_stop_held2", {31'h0, stop_out}, 32'h1);
        wb_read("t1_data_hold", A_DAT, 1'b1, 1'b1, 32'd5);

        // Standalone down continuous, irq disabled
        apply_reset();
        wb_write(A_VAL, 32'd3, 4'hF, 1'b1);
        wb_write(A_CFG, 32'h01, 4'h1, 1'b1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            wb_read("t2_data", A_DAT, 1'b1, 1'b1, 32'(3 - (k % 4)));
            chk("t2_stop", {31'h0, stop_out}, (k > 0 && (k % 4) == 0) ? 32'h1 : 32'h0);
            chk("t2_irq", {31'h0, irq}, 32'h0);
        end

        // Chained up: wrap strobe and is_offset, then enable_in drop
        apply_reset();
        enable_in = 1'b1;
        stop_in = 1'b0;
        wb_write(A_CFG, 32'h0D, 4'h1, 1'b1);
        @(negedge clk);
        wb_read("t3_load", A_DAT, 1'b1, 1'b1, 32'h0);
        wb_write(A_DAT, 32'hFFFF_FFFE, 4'hF, 1'b1);
        wb_read("t3_fe", A_DAT, 1'b1, 1'b1, 32'hFFFF_FFFE);
        chk("t3_offset_fe", {31'h0, is_offset}, 32'h0);
        chk("t3_strobe_fe", {31'h0, strobe}, 32'h0);
        @(negedge clk);
        wb_read("t3_ff", A_DAT, 1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("t3_offset_ff", {31'h0, is_offset}, 32'h1);
        chk("t3_strobe_ff", {31'h0, strobe}, 32'h0);
        @(negedge clk);
        wb_read("t3_wrap", A_DAT, 1'b1, 1'b1, 32'h0);
        chk("t3_strobe_wrap", {31'h0, strobe}, 32'h1);
        chk("t3_offset_wrap", {31'h0, is_offset}, 32'h0);
        @(negedge clk);
        wb_read("t3_after", A_DAT, 1'b1, 1'b1, 32'h1);
        chk("t3_strobe_after", {31'h0, strobe}, 32'h0);
        enable_in = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            wb_read("t3_idle_hold", A_DAT, 1'b1, 1'b1, 32'h1);
            chk("t3_idle_strobe", {31'h0, strobe}, 32'h0);
        end

        // Chained terminal: passes VALUE while stop_in=0, stops once stop_in=1
        apply_reset();
        enable_in = 1'b1;
        stop_in = 1'b0;
        wb_write(A_VAL, 32'd2, 4'hF, 1'b1);
        wb_write(A_CFG, 32'h0F, 4'h1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wb_read("t4_pass", A_DAT, 1'b1, 1'b1, 32'(i));
            chk("t4_pass_stop", {31'h0, stop_out}, 32'h0);
        end
        stop_in = 1'b1;
        wb_write(A_DAT, 32'h0, 4'hF, 1'b1);
        wb_read("t4_rewrite", A_DAT, 1'b1, 1'b1, 32'h0);
        for (int i = 1; i < 3; i++) begin
            @(negedge clk);
            wb_read("t4_count", A_DAT, 1'b1, 1'b1, 32'(i));
            chk("t4_count_stop", {31'h0, stop_out}, 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            wb_read("t4_done", A_DAT, 1'b1, 1'b1, 32'd2);
            chk("t4_done_stop", {31'h0, stop_out}, 32'h1);
        end
        chk("t4_irq", {31'h0, irq}, 32'h0);
        stop_in = 1'b0;
        enable_in = 1'b0;

        // Byte-lane DATA write mid-count, then asynchronous reset mid-count
        apply_reset();
        wb_write(A_VAL, 32'h0FFF_FFFF, 4'hF, 1'b1);
        wb_write(A_CFG, 32'h05, 4'h1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            wb_read("t5_count", A_DAT, 1'b1, 1'b1, 32'(i));
        end
        wb_write(A_DAT, 32'h0000_0100, 4'b0010, 1'b1);
        wb_read("t5_lane1", A_DAT, 1'b1, 1'b1, 32'h0000_0102);
        @(negedge clk);
        wb_read("t5_resume", A_DAT, 1'b1, 1'b1, 32'h0000_0103);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_stop", {31'h0, stop_out}, 32'h0);
        chk("t5_rst_strobe", {31'h0, strobe}, 32'h0);
        chk("t5_rst_irq", {31'h0, irq}, 32'h0);
        chk("t5_rst_enable_out", {31'h0, enable_out}, 32'h0);
        wb_read("t5_rst_cfg", A_CFG, 1'b1, 1'b1, 32'h0);
        wb_read("t5_rst_val", A_VAL, 1'b1, 1'b1, 32'h0);
        @(negedge clk);
        wb_read("t5_rst_dat", A_DAT, 1'b1, 1'b1, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        wb_read("t5_unmapped", 32'h2300_000C, 1'b0, 1'b0, 32'h0);
        wb_read("t5_wrong_base", 32'h0000_0008, 1'b0, 1'b0, 32'h0);
        adr = A_DAT; stb = 1'b1; cyc = 1'b0;
        #1 chk("t5_no_cyc_ack", {31'h0, ack}, 32'h0);
        bus_idle();
        @(negedge clk);
        wb_read("t5_idle_dat", A_DAT, 1'b1, 1'b1, 32'h0);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
